activation_out_fifo: RTL and testbench

Parametrised output buffer between the activation stage and the AHB subordinate register file. It captures each activations_valid beat and presents the oldest entry for bus reads of the output data register. Pops are driven by bus reads, and occupancy and error status are exported for the status register. It supersedes the fixed single-word output holding register with configurable depth and width, an almost-full threshold, flush, and sticky overflow/underflow flags.

---
 rtl/accel_pkg.sv | 22 ++
 rtl/fifo_ptr_ctrl.sv | 84 ++++++++
 rtl/activation_out_fifo.sv | 69 ++++++
 tb/tb_activation_out_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared status bit positions, register offsets and sizing helper
package accel_pkg;

    localparam int OVF_BIT   = 0;
    localparam int UDF_BIT   = 1;
    localparam int EMPTY_BIT = 2;
    localparam int FULL_BIT  = 3;
    localparam int AFULL_BIT = 4;

    localparam logic [7:0] OUT_DATA_OFFSET  = 8'h18;
    localparam logic [7:0] OCCUPANCY_OFFSET = 8'h20;

    function automatic int clog2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, occupancy, status flags and sticky errors (OUTBUF_HWM_EN adds hwm)
module fifo_ptr_ctrl #(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int PTR_W        = 3,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             err_clr,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
`ifdef OUTBUF_HWM_EN
    output logic [CNT_W-1:0] hwm,
`endif
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             ovf_err,
    output logic             udf_err
);

    logic             do_push;
    logic             do_pop;
    logic             ovf_set;
    logic             udf_set;
    logic [CNT_W-1:0] count_next;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AFULL_THRESH));

    // A pop on a full FIFO frees the slot the simultaneous push fills.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        ovf_set    = push && full && !pop && !flush;
        udf_set    = pop && empty && !flush;
        wr_en      = do_push && !flush;
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            count   <= count_next;
            ovf_err <= (ovf_err && !err_clr) || ovf_set;
            udf_err <= (udf_err && !err_clr) || udf_set;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef OUTBUF_HWM_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr)
            hwm <= '0;
        else if (count > hwm)
            hwm <= count;
    end
`endif

endmodule

// File: rtl/activation_out_fifo.sv
// rtl/activation_out_fifo.sv - activation output FIFO with FWFT read port (OUTBUF_HWM_EN adds hwm port)
module activation_out_fifo
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    input  logic                          flush,
    input  logic                          err_clr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [clog2_depth(DEPTH):0]   count,
`ifdef OUTBUF_HWM_EN
    output logic [clog2_depth(DEPTH):0]   hwm,
`endif
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          ovf_err,
    output logic                          udf_err
);

    localparam int PTR_W = clog2_depth(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    fifo_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH),
        .PTR_W        (PTR_W),
        .CNT_W        (CNT_W)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .err_clr     (err_clr),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
`ifdef OUTBUF_HWM_EN
        .hwm         (hwm),
`endif
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // Head is forced to zero when empty so stale storage never reaches the bus.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_activation_out_fifo.sv
// tb/tb_activation_out_fifo.sv - directed self-checking bench for activation_out_fifo
module tb_activation_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [63:0] push_data;
    logic        pop;
    logic        flush;
    logic        err_clr;
    logic [63:0] rd_data;
    logic [3:0]  count;
`ifdef OUTBUF_HWM_EN
    logic [3:0]  hwm;
`endif
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        ovf_err;
    logic        udf_err;

    int checks = 0;
    int errors = 0;

    activation_out_fifo #(
        .DATA_WIDTH   (64),
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .flush       (flush),
        .err_clr     (err_clr),
        .rd_data     (rd_data),
        .count       (count),
`ifdef OUTBUF_HWM_EN
        .hwm         (hwm),
`endif
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic p, input logic [63:0] d, input logic q,
                         input logic f, input logic c);
        push = p; push_data = d; pop = q; flush = f; err_clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if ({count, empty, full, almost_full, ovf_err, udf_err} !== {4'd0, 5'b10000}) begin
            errors++;
            $display("FAIL reset_status: got count=%0d e=%b f=%b af=%b ovf=%b udf=%b, expected 0 1 0 0 0 0",
                     count, empty, full, almost_full, ovf_err, udf_err);
        end
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_order();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h0000_FFFF_0000_EEEE;
        exp_d[1] = 64'h0000_FFFF_0000_AAAA;
        exp_d[2] = 64'h0000_FFFF_0000_BBBB;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_d[i], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== exp_d[i] || count !== 4'(3 - i)) begin
                errors++;
                $display("FAIL order_%0d: got data=%h count=%0d, expected %h %0d", i, rd_data, count, exp_d[i], 3 - i);
            end
            cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 64'h0) begin
            errors++;
            $display("FAIL order_drain: got count=%0d empty=%b data=%h, expected 0 1 0", count, empty, rd_data);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
            if (i == 4) begin
                checks++;
                if (almost_full !== 1'b0 || count !== 4'd5) begin
                    errors++;
                    $display("FAIL afull_below: got af=%b count=%0d, expected 0 5", almost_full, count);
                end
            end
            if (i == 5) begin
                checks++;
                if (almost_full !== 1'b1 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL afull_at6: got af=%b full=%b, expected 1 0", almost_full, full);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || count !== 4'd8 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL full_at8: got full=%b count=%0d ovf=%b, expected 1 8 0", full, count, ovf_err);
        end
        cycle(1'b1, 64'h9999, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovf_err !== 1'b1 || count !== 4'd8 || rd_data !== 64'h100) begin
            errors++;
            $display("FAIL overflow: got ovf=%b count=%0d head=%h, expected 1 8 100", ovf_err, count, rd_data);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf_err);
        end
    endtask

    task automatic test_full_push_pop();
        cycle(1'b1, 64'h1234, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd8 || ovf_err !== 1'b0 || rd_data !== 64'h101) begin
            errors++;
            $display("FAIL full_pushpop: got count=%0d ovf=%b head=%h, expected 8 0 101", count, ovf_err, rd_data);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_data !== 64'h1234 || count !== 4'd1) begin
            errors++;
            $display("FAIL full_pushpop_tail: got head=%h count=%0d, expected 1234 1", rd_data, count);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1 || udf_err !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop_drain: got empty=%b udf=%b, expected 1 0", empty, udf_err);
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (udf_err !== 1'b1 || rd_data !== 64'h0 || count !== 4'd0) begin
            errors++;
            $display("FAIL underflow: got udf=%b data=%h count=%0d, expected 1 0 0", udf_err, rd_data, count);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (udf_err !== 1'b1) begin
            errors++;
            $display("FAIL udf_set_wins: got %b expected 1", udf_err);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (udf_err !== 1'b0) begin
            errors++;
            $display("FAIL udf_clear: got %b expected 0", udf_err);
        end
        cycle(1'b1, 64'hCAFE, 1'b1, 1'b0, 1'b0);
        checks++;
        if (udf_err !== 1'b1 || count !== 4'd1 || rd_data !== 64'hCAFE) begin
            errors++;
            $display("FAIL empty_pushpop: got udf=%b count=%0d head=%h, expected 1 1 cafe", udf_err, count, rd_data);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h500 + 64'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 64'h0) begin
            errors++;
            $display("FAIL flush: got count=%0d empty=%b data=%h, expected 0 1 0", count, empty, rd_data);
        end
        cycle(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rd_data !== 64'h77 || count !== 4'd1) begin
            errors++;
            $display("FAIL post_flush: got head=%h count=%0d, expected 77 1", rd_data, count);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        int bad = 0;
        cycle(1'b1, 64'hA000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 64'hA000 + 64'(i), 1'b1, 1'b0, 1'b0);
            if (rd_data !== 64'hA000 + 64'(i) || count !== 4'd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_order: got %0d mismatched beats, expected 0", bad);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || udf_err !== 1'b0 || rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d empty=%b udf=%b data=%h, expected 0 1 0 0",
                     count, empty, udf_err, rd_data);
        end
    endtask

`ifdef OUTBUF_HWM_EN
    task automatic test_hwm();
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (hwm !== 4'd5) begin
            errors++;
            $display("FAIL hwm_peak: got %0d expected 5", hwm);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (hwm !== 4'd0) begin
            errors++;
            $display("FAIL hwm_clear: got %0d expected 0", hwm);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hwm !== 4'd2) begin
            errors++;
            $display("FAIL hwm_track: got %0d expected 2", hwm);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; push = 1'b0; push_data = '0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_full_push_pop();
        test_underflow();
        test_flush();
        test_wrap();
        test_reset_midstream();
`ifdef OUTBUF_HWM_EN
        test_hwm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
